// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared data bus.
// It decodes DM / Timer0 / Timer1 / IntGen windows, inserts DM wait states
// and returns ack/err/read data to the master that won arbitration.
module bus_arbiter #(
    parameter int unsigned WAIT_DM = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [3:0]  m0_byteen,
    input  logic [31:0] m0_wd,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_byteen,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rd,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wd,
    output logic [3:0]  bus_byteen,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rd,
    output logic        busy
);
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned BEW  = 4;
    localparam int unsigned SELW = 4;
    localparam int unsigned CW   = 4;

    localparam logic [CW-1:0]   WAIT_INIT = CW'(WAIT_DM);
    localparam logic [SELW-1:0] SEL_DM    = SELW'(4'b0001);
    localparam logic [SELW-1:0] SEL_TMR0  = SELW'(4'b0010);
    localparam logic [SELW-1:0] SEL_TMR1  = SELW'(4'b0100);
    localparam logic [SELW-1:0] SEL_INTG  = SELW'(4'b1000);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rr_last_q, rr_last_d;
    logic            win_q, win_d;
    logic            we_q, we_d;
    logic [SELW-1:0] tgt_q, tgt_d;

    logic            m0_ack_d, m0_err_d, m1_ack_d, m1_err_d, busy_d;
    logic [DW-1:0]   m0_rd_d, m1_rd_d, bus_wd_d;
    logic [AW-1:0]   bus_addr_d;
    logic [BEW-1:0]  bus_byteen_d;
    logic [SELW-1:0] bus_sel_d;

    logic            req_any, pick_m1, req_we, done;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wd;
    logic [BEW-1:0]  req_be;
    logic [SELW-1:0] req_tgt;

    // Full 32-bit address decode into a one-hot target; zero means unmapped
    function automatic logic [SELW-1:0] decode(input logic [AW-1:0] a);
        logic [SELW-1:0] s;
        s = '0;
        if (a < 32'h0000_3000)                              s = SEL_DM;
        else if (a >= 32'h0000_7f00 && a <= 32'h0000_7f0b) s = SEL_TMR0;
        else if (a >= 32'h0000_7f10 && a <= 32'h0000_7f1b) s = SEL_TMR1;
        else if (a >= 32'h0000_7f20 && a <= 32'h0000_7f23) s = SEL_INTG;
        return s;
    endfunction

    // Round-robin pick: a lone requester wins, a tie goes to the master not served last
    assign req_any  = m0_req | m1_req;
    assign pick_m1  = m1_req & (~m0_req | ~rr_last_q);
    assign req_addr = pick_m1 ? m1_addr   : m0_addr;
    assign req_wd   = pick_m1 ? m1_wd     : m0_wd;
    assign req_be   = pick_m1 ? m1_byteen : m0_byteen;
    assign req_we   = pick_m1 ? m1_we     : m0_we;
    assign req_tgt  = decode(req_addr);

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_last_d    = rr_last_q;
        win_d        = win_q;
        we_d         = we_q;
        tgt_d        = tgt_q;
        m0_ack_d     = 1'b0;
        m0_err_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m1_err_d     = 1'b0;
        m0_rd_d      = m0_rd;
        m1_rd_d      = m1_rd;
        bus_addr_d   = bus_addr;
        bus_wd_d     = bus_wd;
        bus_byteen_d = '0;
        bus_sel_d    = '0;
        done         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    win_d     = pick_m1;
                    rr_last_d = pick_m1;
                    we_d      = req_we;
                    tgt_d     = req_tgt;
                    if (req_tgt != '0) begin
                        state_d      = ST_ACCESS;
                        bus_sel_d    = req_tgt;
                        bus_addr_d   = req_addr;
                        bus_wd_d     = req_wd;
                        bus_byteen_d = req_we ? req_be : '0;
                    end else begin
                        // Unmapped: answer with an error and leave the bus idle
                        state_d  = ST_RESP;
                        m0_ack_d = ~pick_m1;
                        m0_err_d = ~pick_m1;
                        m1_ack_d = pick_m1;
                        m1_err_d = pick_m1;
                    end
                end
            end
            ST_ACCESS: begin
                if (tgt_q[0] && (WAIT_DM != 0)) begin
                    state_d   = ST_WAIT;
                    cnt_d     = WAIT_INIT;
                    bus_sel_d = tgt_q;
                end else begin
                    done = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done = 1'b1;
                end else begin
                    bus_sel_d = tgt_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion of a mapped access: ack the winner and capture read data
        if (done) begin
            state_d  = ST_RESP;
            m0_ack_d = ~win_q;
            m1_ack_d = win_q;
            if (!we_q) begin
                if (win_q) m1_rd_d = bus_rd;
                else       m0_rd_d = bus_rd;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rr_last_q  <= 1'b1;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            tgt_q      <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rd      <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rd      <= '0;
            bus_addr   <= '0;
            bus_wd     <= '0;
            bus_byteen <= '0;
            bus_sel    <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_last_q  <= rr_last_d;
            win_q      <= win_d;
            we_q       <= we_d;
            tgt_q      <= tgt_d;
            m0_ack     <= m0_ack_d;
            m0_err     <= m0_err_d;
            m0_rd      <= m0_rd_d;
            m1_ack     <= m1_ack_d;
            m1_err     <= m1_err_d;
            m1_rd      <= m1_rd_d;
            bus_addr   <= bus_addr_d;
            bus_wd     <= bus_wd_d;
            bus_byteen <= bus_byteen_d;
            bus_sel    <= bus_sel_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: expected completions are queued when a
// request is driven and popped when the matching ack appears.
module tb_bus_arbiter;
    localparam int WAIT_DM = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_ack, m0_err, m1_ack, m1_err, busy;
    logic [31:0] m0_rd, m1_rd, bus_addr, bus_wd, bus_rd;
    logic [3:0]  bus_byteen, bus_sel;
    logic [31:0] rd_base = 32'h0;

    // Target model: read data depends on the presented address
    assign bus_rd = rd_base ^ bus_addr;

    bus_arbiter #(.WAIT_DM(WAIT_DM)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_byteen(m0_byteen),
        .m0_wd(m0_wd), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_byteen(m1_byteen),
        .m1_wd(m1_wd), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd(m1_rd),
        .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_byteen(bus_byteen),
        .bus_sel(bus_sel), .bus_rd(bus_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m;
        bit          err;
        logic [31:0] rd;
        int          lat;
        logic [3:0]  sel;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl_rd0 = 32'h0, mdl_rd1 = 32'h0;
    int          total = 0, bad = 0;

    // Bus activity monitor: strobe and select cycle counts
    int         strobe_cycles = 0, sel_cycles = 0;
    logic [3:0] last_be = 4'h0, last_sel = 4'h0;
    always @(negedge clk) begin
        if (bus_byteen != 4'h0) begin
            strobe_cycles <= strobe_cycles + 1;
            last_be       <= bus_byteen;
        end
        if (bus_sel != 4'h0) begin
            sel_cycles <= sel_cycles + 1;
            last_sel   <= bus_sel;
        end
    end

    // Reference address map
    function automatic logic [3:0] ref_sel(input logic [31:0] a);
        if (a[31:16] != 16'h0) return 4'b0000;
        if (a[15:0] < 16'h3000) return 4'b0001;
        if (a[15:4] == 12'h7f0 && a[3:0] < 4'hc) return 4'b0010;
        if (a[15:4] == 12'h7f1 && a[3:0] < 4'hc) return 4'b0100;
        if (a[15:2] == 14'h1fc8) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic push_exp(input bit m, input logic [31:0] a, input bit we);
        exp_t e;
        e.sel = ref_sel(a);
        e.m   = m;
        e.err = (e.sel == 4'b0000);
        e.lat = e.err ? 1 : ((e.sel == 4'b0001) ? 2 + WAIT_DM : 2);
        if (!we && !e.err) begin
            if (m) mdl_rd1 = rd_base ^ a;
            else   mdl_rd0 = rd_base ^ a;
        end
        e.rd = m ? mdl_rd1 : mdl_rd0;
        sbq.push_back(e);
    endtask

    task automatic drive(input bit m, input logic [31:0] a, input bit we,
                         input logic [3:0] be, input logic [31:0] wd);
        if (m) begin
            m1_req = 1'b1; m1_addr = a; m1_we = we; m1_byteen = be; m1_wd = wd;
        end else begin
            m0_req = 1'b1; m0_addr = a; m0_we = we; m0_byteen = be; m0_wd = wd;
        end
    endtask

    task automatic wait_ack(input int budget, output bit got, output int lat,
                            output bit a0, output bit a1, output bit e0, output bit e1);
        got = 1'b0; lat = 0; a0 = 1'b0; a1 = 1'b0; e0 = 1'b0; e1 = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                got = 1'b1; a0 = m0_ack; a1 = m1_ack; e0 = m0_err; e1 = m1_err;
            end else begin
                lat++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_byteen = '0; m0_wd = '0;
        m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_byteen = '0; m1_wd = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mdl_rd0 = '0; mdl_rd1 = '0;
        sbq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if ({busy, m0_ack, m1_ack, m0_err, m1_err} !== 5'b0 || bus_sel !== 4'h0 ||
                bus_byteen !== 4'h0 || bus_addr !== 32'h0 || bus_wd !== 32'h0 ||
                m0_rd !== 32'h0 || m1_rd !== 32'h0) begin
                bad++;
                $display("FAIL reset_idle c=%0d busy=%b ack=%b%b err=%b%b sel=%b be=%b addr=%h wd=%h rd0=%h rd1=%h required all 0",
                         c, busy, m0_ack, m1_ack, m0_err, m1_err, bus_sel, bus_byteen, bus_addr, bus_wd, m0_rd, m1_rd);
            end
        end
    endtask

    task automatic test_dm_write();
        exp_t e; bit got, a0, a1, e0, e1; int lat, s0, c0;
        @(posedge clk); #1;
        s0 = strobe_cycles; c0 = sel_cycles;
        rd_base = 32'h0BAD_0000;
        push_exp(1'b0, 32'h0000_0004, 1'b1);
        drive(1'b0, 32'h0000_0004, 1'b1, 4'hF, 32'h1234_5678);
        wait_ack(20, got, lat, a0, a1, e0, e1);
        m0_req = 1'b0;
        e = sbq.pop_front();
        total++; if (!got) begin bad++; $display("FAIL dm_write_timeout no ack within 20 cycles"); end
        total++; if (a0 !== 1'b1 || a1 !== 1'b0) begin bad++; $display("FAIL dm_write_ackdst got m0=%b m1=%b required m0=1 m1=0", a0, a1); end
        total++; if (lat !== e.lat) begin bad++; $display("FAIL dm_write_latency got %0d required %0d", lat, e.lat); end
        total++; if (e0 !== e.err || e1 !== 1'b0) begin bad++; $display("FAIL dm_write_err got %b/%b required %b/0", e0, e1, e.err); end
        total++; if (strobe_cycles - s0 !== 1 || last_be !== 4'hF) begin bad++; $display("FAIL dm_write_strobe got %0d cycles be=%h required 1 cycle be=f", strobe_cycles - s0, last_be); end
        total++; if (last_sel !== e.sel || sel_cycles - c0 !== 1 + WAIT_DM) begin bad++; $display("FAIL dm_write_sel got %b for %0d cycles required %b for %0d", last_sel, sel_cycles - c0, e.sel, 1 + WAIT_DM); end
        total++; if (bus_addr !== 32'h4 || bus_wd !== 32'h1234_5678) begin bad++; $display("FAIL dm_write_bus got addr=%h wd=%h required 00000004/12345678", bus_addr, bus_wd); end
        total++; if (m0_rd !== e.rd) begin bad++; $display("FAIL dm_write_rd got %h required %h", m0_rd, e.rd); end
    endtask

    task automatic test_periph_read();
        exp_t e; bit got, a0, a1, e0, e1; int lat, s0;
        @(posedge clk); #1;
        s0 = strobe_cycles;
        rd_base = 32'h0000_7f04 ^ 32'h0000_00AA;
        push_exp(1'b1, 32'h0000_7f04, 1'b0);
        drive(1'b1, 32'h0000_7f04, 1'b0, 4'hF, 32'hFFFF_FFFF);
        wait_ack(20, got, lat, a0, a1, e0, e1);
        m1_req = 1'b0;
        e = sbq.pop_front();
        total++; if (!got) begin bad++; $display("FAIL t0_read_timeout no ack within 20 cycles"); end
        total++; if (a1 !== 1'b1 || a0 !== 1'b0) begin bad++; $display("FAIL t0_read_ackdst got m0=%b m1=%b required m0=0 m1=1", a0, a1); end
        total++; if (lat !== e.lat) begin bad++; $display("FAIL t0_read_latency got %0d required %0d", lat, e.lat); end
        total++; if (e1 !== 1'b0 || e0 !== 1'b0) begin bad++; $display("FAIL t0_read_err got %b/%b required 0/0", e0, e1); end
        total++; if (m1_rd !== 32'h0000_00AA || m1_rd !== e.rd) begin bad++; $display("FAIL t0_read_data got %h required 000000aa", m1_rd); end
        total++; if (last_sel !== 4'b0010) begin bad++; $display("FAIL t0_read_sel got %b required 0010", last_sel); end
        total++; if (strobe_cycles !== s0) begin bad++; $display("FAIL t0_read_strobe got %0d strobe cycles required 0", strobe_cycles - s0); end
        total++; if (m0_rd !== mdl_rd0) begin bad++; $display("FAIL t0_read_other_rd got %h required %h", m0_rd, mdl_rd0); end
    endtask

    task automatic test_arbitration();
        exp_t e; bit got, a0, a1, e0, e1; int lat, rem0, rem1; bit rr, w;
        do_reset();
        @(posedge clk); #1;
        rd_base = 32'h5500_0000;
        rr = 1'b1; rem0 = 2; rem1 = 2;
        for (int k = 0; k < 4; k++) begin
            w = (rem0 > 0 && rem1 > 0) ? ~rr : (rem0 > 0 ? 1'b0 : 1'b1);
            rr = w;
            if (w) begin push_exp(1'b1, 32'h0000_7f20, 1'b0); rem1--; end
            else   begin push_exp(1'b0, 32'h0000_7f10, 1'b0); rem0--; end
        end
        rem0 = 2; rem1 = 2;
        drive(1'b0, 32'h0000_7f10, 1'b0, 4'h0, 32'h0);
        drive(1'b1, 32'h0000_7f20, 1'b0, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(20, got, lat, a0, a1, e0, e1);
            e = sbq.pop_front();
            if (e.m) begin rem1--; if (rem1 == 0) m1_req = 1'b0; end
            else     begin rem0--; if (rem0 == 0) m0_req = 1'b0; end
            total++; if (!got) begin bad++; $display("FAIL arb_timeout grant %0d not acked", k); end
            total++; if (a0 !== !e.m || a1 !== e.m) begin bad++; $display("FAIL arb_order grant %0d got m0=%b m1=%b required master %0d", k, a0, a1, e.m); end
            total++; if (e0 !== 1'b0 || e1 !== 1'b0) begin bad++; $display("FAIL arb_err grant %0d got %b/%b required 0/0", k, e0, e1); end
            total++; if ((e.m ? m1_rd : m0_rd) !== e.rd) begin bad++; $display("FAIL arb_rd grant %0d got %h required %h", k, e.m ? m1_rd : m0_rd, e.rd); end
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_unmapped();
        exp_t e; bit got, a0, a1, e0, e1; int lat, c0;
        @(posedge clk); #1;
        c0 = sel_cycles;
        rd_base = 32'h1111_0000;
        push_exp(1'b0, 32'h0000_7f24, 1'b0);
        drive(1'b0, 32'h0000_7f24, 1'b0, 4'h0, 32'h0);
        wait_ack(20, got, lat, a0, a1, e0, e1);
        m0_req = 1'b0;
        e = sbq.pop_front();
        total++; if (!got) begin bad++; $display("FAIL unmapped_timeout no ack within 20 cycles"); end
        total++; if (lat !== e.lat) begin bad++; $display("FAIL unmapped_latency got %0d required %0d", lat, e.lat); end
        total++; if (e0 !== 1'b1 || a0 !== 1'b1 || a1 !== 1'b0 || e1 !== 1'b0) begin bad++; $display("FAIL unmapped_err got ack=%b%b err=%b%b required ack=10 err=10", a0, a1, e0, e1); end
        total++; if (sel_cycles !== c0) begin bad++; $display("FAIL unmapped_sel bus_sel active %0d cycles required 0", sel_cycles - c0); end
        total++; if (m0_rd !== e.rd) begin bad++; $display("FAIL unmapped_rd got %h required %h", m0_rd, e.rd); end
        @(negedge clk);
        total++; if (m0_err !== 1'b0 || m0_ack !== 1'b0) begin bad++; $display("FAIL unmapped_err_clear got ack=%b err=%b required 0/0", m0_ack, m0_err); end
    endtask

    task automatic test_decode_edges();
        exp_t e; bit got, a0, a1, e0, e1; int lat, c0; bit m;
        logic [31:0] addrs[10];
        addrs = '{32'h0000_2fff, 32'h0000_3000, 32'h0000_7f00, 32'h0000_7f0b, 32'h0000_7f0c,
                  32'h0000_7f1b, 32'h0000_7f1c, 32'h0000_7f23, 32'h0000_7eff, 32'h0001_0004};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            m = i[0];
            c0 = sel_cycles;
            rd_base = 32'hC0DE_0000 + 32'(i);
            push_exp(m, addrs[i], 1'b0);
            drive(m, addrs[i], 1'b0, 4'h0, 32'h0);
            wait_ack(20, got, lat, a0, a1, e0, e1);
            if (m) m1_req = 1'b0; else m0_req = 1'b0;
            e = sbq.pop_front();
            total++;
            if (!got || lat !== e.lat || a0 !== !m || a1 !== m || (m ? e1 : e0) !== e.err ||
                (m ? e0 : e1) !== 1'b0 || (m ? m1_rd : m0_rd) !== e.rd ||
                (e.err ? (sel_cycles !== c0) : (last_sel !== e.sel))) begin
                bad++;
                $display("FAIL decode_%h got ack=%b lat=%0d err=%b%b rd=%h sel=%b required lat=%0d err=%b rd=%h sel=%b",
                         addrs[i], got, lat, e0, e1, m ? m1_rd : m0_rd, last_sel, e.lat, e.err, e.rd, e.sel);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int s0; bit acked;
        @(posedge clk); #1;
        s0 = strobe_cycles;
        drive(1'b0, 32'h0000_0100, 1'b1, 4'h3, 32'hCAFE_F00D);
        @(negedge clk);
        @(negedge clk);
        total++; if (bus_byteen !== 4'h3 || bus_sel !== 4'b0001) begin bad++; $display("FAIL rstwait_access got be=%h sel=%b required 3/0001", bus_byteen, bus_sel); end
        @(negedge clk);
        total++; if (bus_byteen !== 4'h0 || bus_sel !== 4'b0001 || busy !== 1'b1) begin bad++; $display("FAIL rstwait_wait got be=%h sel=%b busy=%b required 0/0001/1", bus_byteen, bus_sel, busy); end
        reset = 1'b0; m0_req = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || bus_sel !== 4'h0 || bus_byteen !== 4'h0 || bus_addr !== 32'h0 ||
            bus_wd !== 32'h0 || m0_ack !== 1'b0 || m0_rd !== 32'h0 || m1_rd !== 32'h0) begin
            bad++;
            $display("FAIL rstwait_idle got busy=%b sel=%b be=%h addr=%h wd=%h ack=%b rd0=%h rd1=%h required all 0",
                     busy, bus_sel, bus_byteen, bus_addr, bus_wd, m0_ack, m0_rd, m1_rd);
        end
        @(posedge clk); #1 reset = 1'b1;
        mdl_rd0 = '0; mdl_rd1 = '0;
        acked = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack || busy) acked = 1'b1;
        end
        total++; if (acked) begin bad++; $display("FAIL rstwait_no_ack got ack/busy after reset required none"); end
        total++; if (strobe_cycles - s0 !== 1) begin bad++; $display("FAIL rstwait_strobe_once got %0d strobe cycles required 1", strobe_cycles - s0); end
    endtask

    initial begin
        reset = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        test_reset();
        test_dm_write();
        test_periph_read();
        test_arbitration();
        test_unmapped();
        test_decode_edges();
        test_reset_in_wait();
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got %0d entries required 0", sbq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
